// File: rtl/shift_right_iterative.sv
// rtl/shift_right_iterative.sv - multi-cycle logical/arithmetic right shifter with valid/ready handshakes
//
// Purpose:
//   Shifts an N-bit operand right by shamt, resolving one binary stage of the
//   shift amount per clock. Stage s conditionally shifts by 2**s.
//   The result is held in DONE until the consumer takes it.
//
// Optional feature:
//   SHIFT_RIGHT_EARLY_DONE_EN - finish as soon as no higher shamt bits remain.
//   shamt=0 goes straight from IDLE to DONE.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   i_valid  request valid
//   i_ready  block can accept a request (IDLE only)
//   in       operand
//   shamt    shift amount 0..N-1
//   arith    1 = sign fill, 0 = zero fill
//   o_valid  result valid (DONE)
//   o_ready  consumer takes the result
//   out      shifted result
//   busy     high in SHIFT or DONE
module shift_right_iterative #(
  parameter int N = 32,
  parameter int L = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] in,
  input  logic [L-1:0] shamt,
  input  logic         arith,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] out,
  output logic         busy
);

  localparam int SW = $clog2(L);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;

  logic [N-1:0]   r_data;
  logic [N-1:0]   r_out;
  logic [L-1:0]   r_shamt;
  logic           r_arith;
  logic           r_sign;
  logic [SW-1:0]  r_stage;

  logic           w_fill;
  logic [2*N-1:0] w_ext;
  logic [2*N-1:0] w_ext_shifted;
  logic [L-1:0]   w_dist;
  logic [N-1:0]   w_step;
  logic           w_last;
  logic           w_finish;
  logic           w_accept_zero;

  // The sign is taken from the operand as accepted, so later changes on in
  // cannot leak into the fill.
  assign w_fill = r_arith & r_sign;

  // Single 2:1 layer: either the data shifted by 2**stage or the data as-is.
  assign w_ext         = {{N{w_fill}}, r_data};
  assign w_dist        = L'(1) << r_stage;
  assign w_ext_shifted = w_ext >> w_dist;
  assign w_step        = r_shamt[r_stage] ? w_ext_shifted[N-1:0] : r_data;
  assign w_last        = (r_stage == SW'(L - 1));

`ifdef SHIFT_RIGHT_EARLY_DONE_EN
  logic [L-1:0] w_hi;
  logic         w_rest_zero;

  // Bit 0 of w_hi is the current stage; anything above it is still pending.
  assign w_hi          = r_shamt >> r_stage;
  assign w_rest_zero   = (w_hi[L-1:1] == '0);
  assign w_finish      = w_last | w_rest_zero;
  assign w_accept_zero = (shamt == '0);
`else
  assign w_finish      = w_last;
  assign w_accept_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          w_next = w_accept_zero ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_finish) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (o_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_out   <= '0;
      r_shamt <= '0;
      r_arith <= 1'b0;
      r_sign  <= 1'b0;
      r_stage <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_data  <= in;
            r_shamt <= shamt;
            r_arith <= arith;
            r_sign  <= in[N-1];
            r_stage <= '0;
            if (w_accept_zero) begin
              r_out <= in;
            end
          end
        end
        S_SHIFT: begin
          r_data  <= w_step;
          r_stage <= r_stage + SW'(1);
          if (w_finish) begin
            r_out <= w_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign i_ready = (r_state == S_IDLE);
  assign o_valid = (r_state == S_DONE);
  assign busy    = (r_state != S_IDLE);
  assign out     = r_out;

endmodule

// File: tb/tb_shift_right_iterative.sv
// tb/tb_shift_right_iterative.sv - directed self-checking bench for shift_right_iterative
module tb_shift_right_iterative;

  localparam int N = 32;
  localparam int L = 5;

  logic         clk;
  logic         rst;
  logic         i_valid;
  logic         i_ready;
  logic [N-1:0] in;
  logic [L-1:0] shamt;
  logic         arith;
  logic         o_valid;
  logic         o_ready;
  logic [N-1:0] out;
  logic         busy;

  int checks;
  int errors;

  shift_right_iterative #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .in     (in),
    .shamt  (shamt),
    .arith  (arith),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .out    (out),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] v_in;
    logic [L-1:0] v_shamt;
    logic         v_arith;
    logic [N-1:0] v_exp;
  } vec_t;

  vec_t vecs[10];

  // Edges after the accept edge until o_valid is seen.
  function automatic int exp_latency(input logic [L-1:0] sh);
`ifdef SHIFT_RIGHT_EARLY_DONE_EN
    int hb;
    hb = -1;
    for (int b = 0; b < L; b++) if (sh[b]) hb = b;
    return hb + 1;
`else
    return L;
`endif
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after the accept edge; returns edges waited for o_valid.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handoff();
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    o_ready = 1'b0;
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [L-1:0] s, input logic ar,
                        output logic [N-1:0] res, output int lat);
    in      = a;
    shamt   = s;
    arith   = ar;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    in      = ~a;
    shamt   = ~s;
    arith   = ~ar;
    wait_valid(lat);
    res = out;
    handoff();
  endtask

  logic [N-1:0] res;
  logic [N-1:0] held;
  int           lat;
  int           stray;

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    i_valid = 1'b0;
    o_ready = 1'b0;
    in      = '0;
    shamt   = '0;
    arith   = 1'b0;

    vecs[0] = '{32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000};
    vecs[1] = '{32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000};
    vecs[2] = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF};
    vecs[3] = '{32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000};
    vecs[4] = '{32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF};
    vecs[5] = '{32'hDEAD_BEEF, 5'd31, 1'b0, 32'h0000_0001};
    vecs[6] = '{32'h0000_ABCD, 5'd8,  1'b0, 32'h0000_00AB};
    vecs[7] = '{32'hFFFF_0000, 5'd16, 1'b1, 32'hFFFF_FFFF};
    vecs[8] = '{32'h1234_5678, 5'd13, 1'b0, 32'h0000_91A2};
    vecs[9] = '{32'h8765_4321, 5'd7,  1'b1, 32'hFF0E_CA86};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_i_ready", 32'(i_ready), 32'd1);
    check("reset_o_valid", 32'(o_valid), 32'd0);
    check("reset_busy",    32'(busy),    32'd0);
    check("reset_out",     out,          32'd0);

    // o_ready outside DONE must not matter
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    o_ready = 1'b0;
    check("idle_oready_noeffect", 32'(o_valid), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].v_in, vecs[i].v_shamt, vecs[i].v_arith, res, lat);
      check($sformatf("vec%0d_out", i), res, vecs[i].v_exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_latency(vecs[i].v_shamt)));
    end

    // Backpressure plus input toggling during SHIFT/DONE
    in = 32'h8000_0000; shamt = 5'd4; arith = 1'b1; i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    in = 32'h0000_0001; shamt = 5'd1; arith = 1'b0; i_valid = 1'b1;
    check("shift_i_ready", 32'(i_ready), 32'd0);
    check("shift_busy",    32'(busy),    32'd1);
    wait_valid(lat);
    check("bp_result", out, 32'hF800_0000);
    held = out;
    for (int c = 0; c < 3; c++) begin
      in    = in + 32'h1111;
      shamt = shamt + 5'd3;
      @(posedge clk);
      #1;
      check($sformatf("bp_o_valid_%0d", c), 32'(o_valid), 32'd1);
      check($sformatf("bp_out_%0d", c),     out,          held);
      check($sformatf("bp_i_ready_%0d", c), 32'(i_ready), 32'd0);
    end
    i_valid = 1'b0;
    handoff();
    check("bp_after_o_valid", 32'(o_valid), 32'd0);
    check("bp_after_out_kept", out, held);

    // Back-to-back with i_valid held high
    in = 32'h0000_ABCD; shamt = 5'd8; arith = 1'b0; i_valid = 1'b1;
    @(posedge clk);
    #1;
    in = 32'hFFFF_0000; shamt = 5'd16; arith = 1'b1;
    check("b2b_first_busy", 32'(i_ready), 32'd0);
    wait_valid(lat);
    check("b2b_first_out", out, 32'h0000_00AB);
    check("b2b_done_i_ready", 32'(i_ready), 32'd0);
    handoff();
    check("b2b_idle_i_ready", 32'(i_ready), 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    check("b2b_second_accepted", 32'(busy), 32'd1);
    wait_valid(lat);
    check("b2b_second_out", out, 32'hFFFF_FFFF);
    handoff();

    // Reset on the second SHIFT cycle
    in = 32'h1234_5678; shamt = 5'd3; arith = 1'b0; i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_i_ready", 32'(i_ready), 32'd1);
    check("midrst_o_valid", 32'(o_valid), 32'd0);
    check("midrst_busy",    32'(busy),    32'd0);
    check("midrst_out",     out,          32'd0);
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (o_valid) stray++;
    end
    check("midrst_no_stray_valid", 32'(stray), 32'd0);
    run_op(32'h8000_0000, 5'd31, 1'b0, res, lat);
    check("post_rst_out", res, 32'h0000_0001);
    check("post_rst_latency", 32'(lat), 32'(exp_latency(5'd31)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
